// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator.
//   state_t          : per-channel FSM states
//   ADDR_*           : cfg_addr register map
//   MODE_CONT/ONESHOT: value of MODE bit0
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_DELAY  = 2'd2;
  localparam logic [1:0] ADDR_MODE   = 2'd3;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse channel: four config registers, shadow copies, FSM and counter.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : channel enable, low forces IDLE on the next edge
//   trig            : one-shot start request (level, sampled in IDLE only)
//   wr_en           : write strobe for this channel's config registers
//   wr_addr/wr_data : register select and write data
//   pulse           : registered, high exactly while the FSM is in HIGH
//   busy            : registered, high whenever the FSM is not IDLE
module pulse_gen_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 8,
  parameter int DEF_WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             pulse,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Config registers (written any time) and shadows (used by the FSM)
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_width_q, sh_width_d;
  logic             sh_mode_q, sh_mode_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;

  logic             start_period;
  logic             boundary;
  logic [CNT_W-1:0] new_period;
  logic [CNT_W-1:0] new_width;

  always_comb begin
    period_d = period_q;
    width_d  = width_q;
    delay_d  = delay_q;
    mode_d   = mode_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_PERIOD: period_d = wr_data;
        ADDR_WIDTH:  width_d  = wr_data;
        ADDR_DELAY:  delay_d  = wr_data;
        default:     mode_d   = wr_data[0];
      endcase
    end
  end

  // Next-state logic. Shadows always load from the *current* register
  // values, so a write landing on the same edge as a load only takes
  // effect at the following boundary.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_period_d  = sh_period_q;
    sh_width_d   = sh_width_q;
    sh_mode_d    = sh_mode_q;
    start_period = 1'b0;
    boundary     = 1'b0;
    new_period   = sh_period_q;
    new_width    = sh_width_q;

    case (state_q)
      ST_IDLE: begin
        if (en && (period_q != '0) && ((mode_q == MODE_CONT) || trig)) begin
          sh_period_d = period_q;
          sh_width_d  = width_q;
          sh_mode_d   = mode_q;
          if (delay_q != '0) begin
            state_d = ST_DELAY;
            cnt_d   = delay_q - ONE;
          end else begin
            start_period = 1'b1;
            new_period   = period_q;
            new_width    = width_q;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else             start_period = 1'b1;
      end
      ST_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (sh_width_q >= sh_period_q) begin
          // The whole period was HIGH: no LOW phase at all
          if (sh_mode_q == MODE_ONESHOT) state_d = ST_IDLE;
          else                           boundary = 1'b1;
        end else begin
          state_d = ST_LOW;
          cnt_d   = sh_period_q - sh_width_q - ONE;
        end
      end
      default: begin // ST_LOW
        if (cnt_q != '0)                    cnt_d = cnt_q - ONE;
        else if (sh_mode_q == MODE_ONESHOT) state_d = ST_IDLE;
        else                                boundary = 1'b1;
      end
    endcase

    // Period boundary in continuous mode: pick up fresh configuration
    if (boundary) begin
      sh_period_d = period_q;
      sh_width_d  = width_q;
      sh_mode_d   = mode_q;
      new_period  = period_q;
      new_width   = width_q;
      if (period_q == '0) state_d = ST_IDLE;
      else                start_period = 1'b1;
    end

    // First phase of a period; WIDTH=0 skips HIGH and spends it all in LOW
    if (start_period) begin
      if (new_width == '0) begin
        state_d = ST_LOW;
        cnt_d   = new_period - ONE;
      end else begin
        state_d = ST_HIGH;
        cnt_d   = ((new_width < new_period) ? new_width : new_period) - ONE;
      end
    end

    if (!en) state_d = ST_IDLE;
    if (state_d == ST_IDLE) cnt_d = '0;

    // Outputs are registered from the next state so they line up with state_q
    pulse_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q    <= CNT_W'(DEF_PERIOD);
      width_q     <= CNT_W'(DEF_WIDTH);
      delay_q     <= '0;
      mode_q      <= MODE_CONT;
      sh_period_q <= CNT_W'(DEF_PERIOD);
      sh_width_q  <= CNT_W'(DEF_WIDTH);
      sh_mode_q   <= MODE_CONT;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      period_q    <= period_d;
      width_q     <= width_d;
      delay_q     <= delay_d;
      mode_q      <= mode_d;
      sh_period_q <= sh_period_d;
      sh_width_q  <= sh_width_d;
      sh_mode_q   <= sh_mode_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel runtime-programmable pulse generator.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en[NUM_CH]        : per-channel enable
//   trig[NUM_CH]      : per-channel one-shot start
//   cfg_we            : config write strobe
//   cfg_ch            : target channel (codes >= NUM_CH are ignored)
//   cfg_addr          : 0 PERIOD, 1 WIDTH, 2 DELAY, 3 MODE
//   cfg_data          : write data
//   pulse[NUM_CH]     : registered pulse outputs
//   busy[NUM_CH]      : channel not IDLE
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  CNT_W      = 16,
  parameter int  DEF_PERIOD = 8,
  parameter int  DEF_WIDTH  = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] trig,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] wr_en;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Full-width compare: out-of-range channel codes match no instance
      assign wr_en[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      pulse_gen_chan #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_WIDTH  (DEF_WIDTH)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en[gi]),
        .trig    (trig[gi]),
        .wr_en   (wr_en[gi]),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .pulse   (pulse[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: table rows, hand sequences for the multi-cycle
// corners, then random traffic against a position-in-period reference model.
// Five channels are used so that cfg_ch has codes that name no channel.
module tb_pulse_gen_multi;
  import pulse_gen_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NUM_CH-1:0] en, trig;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_addr;
  logic [CNT_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] pulse, busy;

  pulse_gen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(8), .DEF_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pulse(pulse), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: registers, shadows, and where the channel sits in time
  // (remaining delay cycles, then position inside the current period).
  int rp[NUM_CH], rw[NUM_CH], rd[NUM_CH], rm[NUM_CH];
  int act[NUM_CH], dly[NUM_CH], pos[NUM_CH];
  int sp[NUM_CH], sw[NUM_CH], sm[NUM_CH];

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        rp[c] = 8; rw[c] = 2; rd[c] = 0; rm[c] = 0;
        act[c] = 0; dly[c] = 0; pos[c] = 0;
      end else begin
        if (!en[c]) begin
          act[c] = 0;
        end else if (act[c] == 0) begin
          if (rp[c] != 0 && (rm[c] == 0 || trig[c])) begin
            act[c] = 1; sp[c] = rp[c]; sw[c] = rw[c]; sm[c] = rm[c];
            dly[c] = rd[c]; pos[c] = 0;
          end
        end else if (dly[c] > 0) begin
          dly[c]--;
        end else begin
          pos[c]++;
          if (pos[c] == sp[c]) begin
            pos[c] = 0;
            if (sm[c] != 0) act[c] = 0;
            else begin
              sp[c] = rp[c]; sw[c] = rw[c]; sm[c] = rm[c];
              if (sp[c] == 0) act[c] = 0;
            end
          end
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          case (cfg_addr)
            2'd0: rp[c] = int'(cfg_data);
            2'd1: rw[c] = int'(cfg_data);
            2'd2: rd[c] = int'(cfg_data);
            default: rm[c] = int'(cfg_data[0]);
          endcase
        end
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_pulse();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++)
      v[c] = (act[c] != 0) && (dly[c] == 0) && (pos[c] < ((sw[c] < sp[c]) ? sw[c] : sp[c]));
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_busy();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = (act[c] != 0);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] bitv(int c, bit b);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[c] = b;
    return v;
  endfunction

  task automatic check(string name, logic [NUM_CH-1:0] got, logic [NUM_CH-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // One clock: DUT and model see the same inputs; compare 1 time unit later
  task automatic tick(string tag);
    if (cfg_we && !rst)
      $display("[%0t] %s: cfg write ch%0d addr%0d data %0d", $time, tag, cfg_ch, cfg_addr, cfg_data);
    @(posedge clk);
    model_step();
    #1;
    check({tag, " pulse/model"}, pulse, model_pulse());
    check({tag, " busy/model"}, busy, model_busy());
  endtask

  task automatic wr(int ch, logic [1:0] addr, int data, string tag);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_addr = addr; cfg_data = CNT_W'(data);
    tick(tag);
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] trig;
    logic              we;
    logic [CH_W-1:0]   ch;
    logic [1:0]        addr;
    logic [CNT_W-1:0]  data;
    logic [NUM_CH-1:0] exp_pulse;
    logic [NUM_CH-1:0] exp_busy;
  } vec_t;

  vec_t tbl[$];
  int ta_lo, ta_hi, tb_lo, tb_hi;

  function automatic vec_t mk(logic [NUM_CH-1:0] e, logic [NUM_CH-1:0] t, logic we,
                              int ch, logic [1:0] addr, int data,
                              logic [NUM_CH-1:0] ep, logic [NUM_CH-1:0] eb);
    vec_t v;
    v.en = e; v.trig = t; v.we = we; v.ch = CH_W'(ch); v.addr = addr;
    v.data = CNT_W'(data); v.exp_pulse = ep; v.exp_busy = eb;
    return v;
  endfunction

  task automatic apply_rows(int lo, int hi, string tag);
    for (int i = lo; i < hi; i++) begin
      en = tbl[i].en; trig = tbl[i].trig; cfg_we = tbl[i].we;
      cfg_ch = tbl[i].ch; cfg_addr = tbl[i].addr; cfg_data = tbl[i].data;
      tick(tag);
      check($sformatf("%s row %0d pulse", tag, i - lo), pulse, tbl[i].exp_pulse);
      check($sformatf("%s row %0d busy", tag, i - lo), busy, tbl[i].exp_busy);
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; trig = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_addr = '0; cfg_data = '0;

    // Table A: ch0 on reset defaults (PERIOD 8, WIDTH 2), 20 cycles then en off
    ta_lo = tbl.size();
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk(bitv(0, 1), '0, 1'b0, 0, 2'd0, 0, bitv(0, (i % 8) < 2), bitv(0, 1)));
    tbl.push_back(mk('0, '0, 1'b0, 0, 2'd0, 0, '0, '0));
    ta_hi = tbl.size();

    // Table B: ch1 DELAY 5, PERIOD 10, WIDTH 3; ends mid-HIGH of third pulse
    tb_lo = tbl.size();
    tbl.push_back(mk('0, '0, 1'b1, 1, ADDR_DELAY, 5, '0, '0));
    tbl.push_back(mk('0, '0, 1'b1, 1, ADDR_PERIOD, 10, '0, '0));
    tbl.push_back(mk('0, '0, 1'b1, 1, ADDR_WIDTH, 3, '0, '0));
    for (int i = 0; i < 27; i++)
      tbl.push_back(mk(bitv(1, 1), '0, 1'b0, 0, 2'd0, 0,
                       bitv(1, (i >= 5) && (((i - 5) % 10) < 3)), bitv(1, 1)));
    tb_hi = tbl.size();

    // Reset state
    tick("reset");
    check("reset pulse", pulse, '0);
    check("reset busy", busy, '0);
    tick("reset");
    rst = 1'b0;

    apply_rows(ta_lo, ta_hi, "ch0 defaults");
    apply_rows(tb_lo, tb_hi, "ch1 delay");
    en = '0;
    tick("ch1 en drop");
    check("ch1 en drop pulse", pulse, '0);
    check("ch1 en drop busy", busy, '0);

    // ch2 one-shot: trig at k=0 fires, k=3 ignored (busy), k=7 fires again
    wr(2, ADDR_PERIOD, 6, "ch2 cfg");
    wr(2, ADDR_WIDTH, 1, "ch2 cfg");
    wr(2, ADDR_MODE, 1, "ch2 cfg");
    en = bitv(2, 1);
    for (int k = 0; k < 10; k++) begin
      trig = bitv(2, (k == 0) || (k == 3) || (k == 7));
      tick("ch2 oneshot");
      check($sformatf("ch2 oneshot k%0d pulse", k), pulse, bitv(2, (k == 0) || (k == 7)));
      check($sformatf("ch2 oneshot k%0d busy", k), busy, bitv(2, (k < 6) || (k >= 7)));
    end
    en = '0; trig = '0;
    tick("ch2 off");

    // ch3 boundaries: WIDTH=PERIOD, WIDTH=0, PERIOD=0
    wr(3, ADDR_PERIOD, 8, "ch3 cfg");
    wr(3, ADDR_WIDTH, 8, "ch3 cfg");
    en = bitv(3, 1);
    for (int k = 0; k < 20; k++) begin
      tick("ch3 w=p");
      check($sformatf("ch3 w=p k%0d pulse", k), pulse, bitv(3, 1));
    end
    en = '0;
    tick("ch3 off");
    wr(3, ADDR_WIDTH, 0, "ch3 cfg");
    en = bitv(3, 1);
    for (int k = 0; k < 20; k++) begin
      tick("ch3 w=0");
      check($sformatf("ch3 w=0 k%0d pulse", k), pulse, '0);
      check($sformatf("ch3 w=0 k%0d busy", k), busy, bitv(3, 1));
    end
    en = '0;
    tick("ch3 off");
    wr(3, ADDR_PERIOD, 0, "ch3 cfg");
    en = bitv(3, 1);
    for (int k = 0; k < 10; k++) begin
      tick("ch3 p=0");
      check($sformatf("ch3 p=0 k%0d busy", k), busy, '0);
    end
    en = '0;
    tick("ch3 off");

    // ch0 PERIOD 8->4 during HIGH; writes to ch7/5/6 must change nothing
    en = bitv(0, 1) | bitv(4, 1);
    for (int k = 0; k < 16; k++) begin
      cfg_we   = (k >= 1) && (k <= 4);
      cfg_ch   = (k == 1) ? 3'd0 : (k == 2) ? 3'd7 : (k == 3) ? 3'd5 : 3'd6;
      cfg_addr = (k <= 2) ? ADDR_PERIOD : (k == 3) ? ADDR_WIDTH : ADDR_MODE;
      cfg_data = (k == 1) ? 16'd4 : (k == 2) ? 16'd3 : (k == 3) ? 16'd5 : 16'd1;
      tick("mid write");
      check($sformatf("mid write k%0d pulse", k), pulse,
            bitv(0, (k < 2) || ((k >= 8) && (((k - 8) % 4) < 2))) | bitv(4, (k % 8) < 2));
      check($sformatf("mid write k%0d busy", k), busy, bitv(0, 1) | bitv(4, 1));
    end
    cfg_we = 1'b0;

    // Reset with everything running, then defaults must be back on ch0
    en = '1; trig = '1;
    for (int k = 0; k < 6; k++) tick("all active");
    rst = 1'b1;
    tick("mid reset");
    check("mid reset pulse", pulse, '0);
    check("mid reset busy", busy, '0);
    rst = 1'b0; en = '0; trig = '0;
    tick("post reset");
    apply_rows(ta_lo, ta_hi, "ch0 defaults again");

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(499) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(39) == 0) en[c] = ~en[c];
        trig[c] = ($urandom_range(5) == 0);
      end
      cfg_we   = ($urandom_range(3) == 0);
      cfg_ch   = CH_W'($urandom_range(7));
      cfg_addr = 2'($urandom_range(3));
      case (cfg_addr)
        ADDR_PERIOD: cfg_data = ($urandom_range(9) == 0) ? '0 : CNT_W'($urandom_range(12, 1));
        ADDR_WIDTH:  cfg_data = CNT_W'($urandom_range(14));
        ADDR_DELAY:  cfg_data = CNT_W'($urandom_range(4));
        default:     cfg_data = CNT_W'($urandom_range(1));
      endcase
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
